// File: rtl/sar_conv_scheduler.sv
// sar_conv_scheduler: round-robin sharing of one 4-bit SAR core and its sample/hold
//   front end among NUM_CH requesters. Per grant it samples, converts, then returns
//   {res_ch, res_data, res_err} on a valid/ready port and pulses ack for the channel.
// Latency: grant -> res_valid = 1 + SAMPLE_CYCLES + 6 cycles with a 5-cycle core.
// Backpressure: RESULT holds res_* stable until res_ready; no new grant meanwhile.
// Ports: clk/reset (sync, active-high); req[NUM_CH] in, ack[NUM_CH] out; ch_sel,
//   sh_sample, sar_rst drive the front end/core; sar_bits, sar_done from the core;
//   res_valid/res_ready/res_data/res_ch/res_err result port; busy = not IDLE.
// Build option: define SAR_SCHED_AVG_EN to average 4 conversions per grant.
module sar_conv_scheduler #(
  parameter int NUM_CH         = 4,
  parameter int CH_W           = $clog2(NUM_CH),
  parameter int SAMPLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] ack,
  output logic [CH_W-1:0]   ch_sel,
  output logic              sh_sample,
  output logic              sar_rst,
  input  logic [3:0]        sar_bits,
  input  logic              sar_done,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [3:0]        res_data,
  output logic [CH_W-1:0]   res_ch,
  output logic              res_err,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_CONVERT, S_RESULT} state_t;

  localparam int CNT_MAX = (SAMPLE_CYCLES > TIMEOUT_CYCLES) ? SAMPLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST  = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
  logic [CH_W-1:0]   last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        res_data_q, res_data_d;
  logic              res_err_q, res_err_d;
  logic              grant_vld;
  logic [CH_W-1:0]   grant_ch;
`ifdef SAR_SCHED_AVG_EN
  logic [5:0]        acc_q, acc_d;
  logic [1:0]        pass_q, pass_d;
  logic [5:0]        acc_sum;
  assign acc_sum = acc_q + {2'b00, sar_bits};
`endif

  // Channel index base+off, wrapped modulo NUM_CH (works for non-power-of-2 counts).
  function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_CH) s = s - NUM_CH;
    return CH_W'(s);
  endfunction

  // Round-robin: first requester after last_grant; last_grant itself is checked last.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!grant_vld && req[wrap_add(last_grant_q, i)]) begin
        grant_vld = 1'b1;
        grant_ch  = wrap_add(last_grant_q, i);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ch_sel_q     <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
      cnt_q        <= '0;
      res_data_q   <= '0;
      res_err_q    <= 1'b0;
`ifdef SAR_SCHED_AVG_EN
      acc_q        <= '0;
      pass_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ch_sel_q     <= ch_sel_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      res_data_q   <= res_data_d;
      res_err_q    <= res_err_d;
`ifdef SAR_SCHED_AVG_EN
      acc_q        <= acc_d;
      pass_q       <= pass_d;
`endif
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d      = state_q;
    ch_sel_d     = ch_sel_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    res_data_d   = res_data_q;
    res_err_d    = res_err_q;
`ifdef SAR_SCHED_AVG_EN
    acc_d        = acc_q;
    pass_d       = pass_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          ch_sel_d     = grant_ch;
          last_grant_d = grant_ch;
          cnt_d        = '0;
          res_err_d    = 1'b0;
`ifdef SAR_SCHED_AVG_EN
          acc_d        = '0;
          pass_d       = '0;
`endif
          state_d      = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (cnt_q == SAMPLE_LAST) begin
          cnt_d   = '0;
          state_d = S_CONVERT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CONVERT: begin
        // A done on the final allowed cycle still counts as a good conversion.
        if (sar_done) begin
`ifdef SAR_SCHED_AVG_EN
          if (pass_q == 2'd3) begin
            res_data_d = acc_sum[5:2];
            state_d    = S_RESULT;
          end else begin
            acc_d   = acc_sum;
            pass_d  = pass_q + 1'b1;
            cnt_d   = '0;
            state_d = S_SAMPLE;
          end
`else
          res_data_d = sar_bits;
          state_d    = S_RESULT;
`endif
        end else if (cnt_q == TIMEOUT_LAST) begin
          res_data_d = '0;
          res_err_d  = 1'b1;
          state_d    = S_RESULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESULT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: pure functions of state, plus the handshake for ack.
  always_comb begin
    ack            = '0;
    sh_sample      = (state_q == S_SAMPLE);
    sar_rst        = (state_q != S_CONVERT);
    res_valid      = (state_q == S_RESULT);
    busy           = (state_q != S_IDLE);
    ch_sel         = ch_sel_q;
    res_ch         = ch_sel_q;
    res_data       = res_data_q;
    res_err        = res_err_q;
    if (state_q == S_RESULT && res_ready) ack[ch_sel_q] = 1'b1;
  end

endmodule

// File: tb/tb_sar_conv_scheduler.sv
// tb_sar_conv_scheduler: directed bench for sar_conv_scheduler with a 5-cycle SAR core
//   model (done on the 6th cycle after release), checked with immediate assertions.
// Ports: drives clk/reset/req/sar_bits/sar_done/res_ready, observes all outputs.
module tb_sar_conv_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] ack;
  logic [1:0] ch_sel;
  logic       sh_sample;
  logic       sar_rst;
  logic [3:0] sar_bits;
  logic       sar_done;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic [1:0] res_ch;
  logic       res_err;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  // SAR core model
  logic [3:0] vals [4];
  logic [1:0] vidx = 2'd0;
  int         rcnt = 0;
  logic       model_done = 1'b0;
  logic       done_en;
  logic       force_done;

  assign sar_bits = vals[vidx];
  assign sar_done = model_done | force_done;

  sar_conv_scheduler #(.NUM_CH(4), .CH_W(2), .SAMPLE_CYCLES(2), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .reset(reset), .req(req), .ack(ack), .ch_sel(ch_sel),
    .sh_sample(sh_sample), .sar_rst(sar_rst), .sar_bits(sar_bits), .sar_done(sar_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_ch(res_ch),
    .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) vidx = 2'd0;
    else if (model_done) vidx = vidx + 2'd1;
    if (sar_rst !== 1'b0) begin
      rcnt       = 0;
      model_done = 1'b0;
    end else begin
      rcnt       = rcnt + 1;
      model_done = done_en && (rcnt == 6);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_vals(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
    vals[0] = a; vals[1] = b; vals[2] = c; vals[3] = d;
  endtask

  // Counts cycles from the current (grant) cycle until res_valid, bounded.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (res_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    check("res_valid_seen", {31'd0, res_valid}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},       {28'd0, ack},       32'd0);
    check({tag, "_ch_sel"},    {30'd0, ch_sel},    32'd0);
    check({tag, "_sh_sample"}, {31'd0, sh_sample}, 32'd0);
    check({tag, "_sar_rst"},   {31'd0, sar_rst},   32'd1);
    check({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
    check({tag, "_res_data"},  {28'd0, res_data},  32'd0);
    check({tag, "_res_ch"},    {30'd0, res_ch},    32'd0);
    check({tag, "_res_err"},   {31'd0, res_err},   32'd0);
    check({tag, "_busy"},      {31'd0, busy},      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat;
    int order [5];
    int acks;
    order = '{0, 1, 2, 3, 0};
    reset = 1'b1; req = 4'd0; res_ready = 1'b0; done_en = 1'b1; force_done = 1'b0;
    set_vals(4'hA, 4'hA, 4'hA, 4'hA);
    tick(); tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

`ifndef SAR_SCHED_AVG_EN
    // 1) single request on channel 0
    req = 4'b0001;
    tick();
    check("t1_sample_sh", {31'd0, sh_sample}, 32'd1);
    check("t1_sample_rst", {31'd0, sar_rst}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    tick();
    check("t1_sample2_sh", {31'd0, sh_sample}, 32'd1);
    tick();
    check("t1_conv_rst", {31'd0, sar_rst}, 32'd0);
    check("t1_conv_sh", {31'd0, sh_sample}, 32'd0);
    wait_valid(lat);
    check("t1_latency", lat + 3, 32'd9);
    check("t1_data", {28'd0, res_data}, 32'hA);
    check("t1_ch", {30'd0, res_ch}, 32'd0);
    check("t1_err", {31'd0, res_err}, 32'd0);
    check("t1_no_ack", {28'd0, ack}, 32'd0);
    res_ready = 1'b1; #1;
    check("t1_ack", {28'd0, ack}, 32'b0001);
    req = 4'd0;
    tick();
    check("t1_valid_drop", {31'd0, res_valid}, 32'd0);
    check("t1_ack_drop", {28'd0, ack}, 32'd0);
    check("t1_idle", {31'd0, busy}, 32'd0);
    res_ready = 1'b0;

    // 2) all channels requesting: fair rotation from channel 0
    reset = 1'b1; tick(); reset = 1'b0;
    set_vals(4'h5, 4'h5, 4'h5, 4'h5);
    req = 4'b1111; res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_valid(lat);
      check("t2_latency", lat, 32'd9);
      check("t2_ch", {30'd0, res_ch}, order[k]);
      check("t2_ack", {28'd0, ack}, 32'd1 << order[k]);
      tick();
    end
    req = 4'd0;
    res_ready = 1'b0;

    // 3) backpressure holds the result
    set_vals(4'h3, 4'h3, 4'h3, 4'h3);
    req = 4'b0100;
    wait_valid(lat);
    check("t3_latency", lat, 32'd9);
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_valid", {31'd0, res_valid}, 32'd1);
      check("t3_hold_data", {28'd0, res_data}, 32'h3);
      check("t3_hold_ch", {30'd0, res_ch}, 32'd2);
      check("t3_hold_ack", {28'd0, ack}, 32'd0);
      check("t3_hold_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    res_ready = 1'b1; #1;
    check("t3_ack", {28'd0, ack}, 32'b0100);
    req = 4'd0;
    tick();
    check("t3_valid_drop", {31'd0, res_valid}, 32'd0);
    res_ready = 1'b0;

    // 4) core never finishes -> timeout abort, then a normal conversion
    done_en = 1'b0;
    req = 4'b0010;
    wait_valid(lat);
    check("t4_timeout_latency", lat, 32'd18);
    check("t4_err", {31'd0, res_err}, 32'd1);
    check("t4_data", {28'd0, res_data}, 32'd0);
    check("t4_ch", {30'd0, res_ch}, 32'd1);
    res_ready = 1'b1; #1;
    check("t4_ack", {28'd0, ack}, 32'b0010);
    req = 4'd0;
    tick();
    res_ready = 1'b0;
    done_en = 1'b1;
    set_vals(4'h9, 4'h9, 4'h9, 4'h9);
    req = 4'b1000;
    wait_valid(lat);
    check("t4_next_latency", lat, 32'd9);
    check("t4_next_err", {31'd0, res_err}, 32'd0);
    check("t4_next_data", {28'd0, res_data}, 32'h9);
    check("t4_next_ch", {30'd0, res_ch}, 32'd3);
    res_ready = 1'b1; #1;
    check("t4_next_ack", {28'd0, ack}, 32'b1000);
    req = 4'd0;
    tick();
    res_ready = 1'b0;

    // 5) spurious done outside CONVERT, then reset mid-conversion
    reset = 1'b1; tick(); reset = 1'b0;
    set_vals(4'hC, 4'hC, 4'hC, 4'hC);
    force_done = 1'b1;
    tick();
    check("t5_idle_done_busy", {31'd0, busy}, 32'd0);
    check("t5_idle_done_valid", {31'd0, res_valid}, 32'd0);
    req = 4'b0100;
    tick();
    check("t5_sample1_sh", {31'd0, sh_sample}, 32'd1);
    check("t5_sample1_ch", {30'd0, ch_sel}, 32'd2);
    tick();
    check("t5_sample2_sh", {31'd0, sh_sample}, 32'd1);
    force_done = 1'b0;
    tick();
    check("t5_conv_rst", {31'd0, sar_rst}, 32'd0);
    tick();
    check("t5_conv_valid", {31'd0, res_valid}, 32'd0);
    check("t5_conv_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1; req = 4'd0;
    tick();
    check_reset_outputs("t5_midreset");
    reset = 1'b0;
    tick(); tick();
    check("t5_after_busy", {31'd0, busy}, 32'd0);
    check("t5_after_valid", {31'd0, res_valid}, 32'd0);
`else
    // 6) four-pass averaging: 5+6+6+7 = 24 -> 6
    set_vals(4'h5, 4'h6, 4'h6, 4'h7);
    req = 4'b0001;
    acks = 0;
    lat = 0;
    while (res_valid !== 1'b1 && lat < 200) begin
      tick();
      lat++;
      if (ack !== 4'd0) acks++;
    end
    check("t6_valid_seen", {31'd0, res_valid}, 32'd1);
    check("t6_latency", lat, 32'd33);
    check("t6_early_acks", acks, 32'd0);
    check("t6_data", {28'd0, res_data}, 32'h6);
    check("t6_err", {31'd0, res_err}, 32'd0);
    check("t6_ch", {30'd0, res_ch}, 32'd0);
    res_ready = 1'b1; #1;
    check("t6_ack", {28'd0, ack}, 32'b0001);
    req = 4'd0;
    tick();
    check("t6_ack_drop", {28'd0, ack}, 32'd0);
    check("t6_valid_drop", {31'd0, res_valid}, 32'd0);
    check("t6_idle", {31'd0, busy}, 32'd0);
    res_ready = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
